// File: rtl/chip8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : chip8_pkg
// Description : Shared types and constants for the CHIP-8 execute sequencer:
//               ALU command encoding, sequencer states, opcode classes.
// Revision    : 1.0 - initial release
// ============================================================================
package chip8_pkg;

  // Fetch address after reset
  localparam logic [11:0] c_pc_reset = 12'h200;

  // Top-nibble opcode groups handled by the sequencer
  localparam logic [3:0] c_opc_jp      = 4'h1;
  localparam logic [3:0] c_opc_se_kk   = 4'h3;
  localparam logic [3:0] c_opc_sne_kk  = 4'h4;
  localparam logic [3:0] c_opc_se_vy   = 4'h5;
  localparam logic [3:0] c_opc_ld_kk   = 4'h6;
  localparam logic [3:0] c_opc_add_kk  = 4'h7;
  localparam logic [3:0] c_opc_alu     = 4'h8;
  localparam logic [3:0] c_opc_sne_vy  = 4'h9;

  // Index of the flag register
  localparam logic [3:0] c_vf_idx = 4'hF;

  typedef enum logic [3:0] {
    ALU_MOV  = 4'h0,
    ALU_OR   = 4'h1,
    ALU_AND  = 4'h2,
    ALU_XOR  = 4'h3,
    ALU_ADD  = 4'h4,
    ALU_SUB  = 4'h5,
    ALU_SHR  = 4'h6,
    ALU_SUBN = 4'h7,
    ALU_SHL  = 4'hE
  } alu_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_HI = 3'd1,
    S_FETCH_LO = 3'd2,
    S_DECODE   = 3'd3,
    S_READ     = 3'd4,
    S_EXEC     = 3'd5,
    S_ILLEGAL  = 3'd6
  } seq_state_t;

  typedef enum logic [3:0] {
    OP_NONE       = 4'd0,
    OP_JUMP       = 4'd1,
    OP_SKIP_EQ_KK = 4'd2,
    OP_SKIP_NE_KK = 4'd3,
    OP_SKIP_EQ_VY = 4'd4,
    OP_SKIP_NE_VY = 4'd5,
    OP_LOAD_KK    = 4'd6,
    OP_ADD_KK     = 4'd7,
    OP_ALU        = 4'd8
  } op_class_t;

endpackage
`default_nettype wire

// File: rtl/chip8_exec_sequencer_decode.sv
`default_nettype none
// ============================================================================
// Module      : chip8_decode
// Description : Combinational opcode classifier. Maps the instruction word
//               to legality, op class, ALU command and writeback flags.
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_decode
  import chip8_pkg::*;
(
  input  logic [15:0] ir,
  output logic        is_legal,
  output op_class_t   op_class,
  output alu_cmd_t    alu_cmd,
  output logic        writes_vx,
  output logic        writes_vf
);

  // Classify the opcode; anything not listed stays illegal
  always_comb begin
    is_legal  = 1'b0;
    op_class  = OP_NONE;
    alu_cmd   = ALU_MOV;
    writes_vx = 1'b0;
    writes_vf = 1'b0;
    case (ir[15:12])
      c_opc_jp: begin
        is_legal = 1'b1;
        op_class = OP_JUMP;
      end
      c_opc_se_kk: begin
        is_legal = 1'b1;
        op_class = OP_SKIP_EQ_KK;
      end
      c_opc_sne_kk: begin
        is_legal = 1'b1;
        op_class = OP_SKIP_NE_KK;
      end
      c_opc_se_vy: begin
        is_legal = (ir[3:0] == 4'h0);
        op_class = OP_SKIP_EQ_VY;
      end
      c_opc_sne_vy: begin
        is_legal = (ir[3:0] == 4'h0);
        op_class = OP_SKIP_NE_VY;
      end
      c_opc_ld_kk: begin
        is_legal  = 1'b1;
        op_class  = OP_LOAD_KK;
        writes_vx = 1'b1;
      end
      c_opc_add_kk: begin
        is_legal  = 1'b1;
        op_class  = OP_ADD_KK;
        alu_cmd   = ALU_ADD;
        writes_vx = 1'b1;
      end
      c_opc_alu: begin
        op_class = OP_ALU;
        case (ir[3:0])
          4'h0, 4'h1, 4'h2, 4'h3: begin
            is_legal  = 1'b1;
            alu_cmd   = alu_cmd_t'(ir[3:0]);
            writes_vx = 1'b1;
          end
          4'h4, 4'h5, 4'h6, 4'h7, 4'hE: begin
            is_legal  = 1'b1;
            alu_cmd   = alu_cmd_t'(ir[3:0]);
            writes_vx = 1'b1;
            writes_vf = 1'b1;
          end
          default: is_legal = 1'b0;
        endcase
      end
      default: is_legal = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/chip8_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : chip8_exec_sequencer
// Description : Fetch/decode/execute controller for the CHIP-8 datapath.
//               Fetches big-endian opcodes, sequences register reads, ALU
//               use and writebacks, and owns the program counter.
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_exec_sequencer
  import chip8_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] PC_RESET = ADDR_W'(c_pc_reset)
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [7:0]        mem_rdata,
  output logic [3:0]        reg_addr1,
  output logic [3:0]        reg_addr2,
  output logic [7:0]        reg_writedata1,
  output logic              reg_WE1,
  output logic [7:0]        reg_VFwritedata,
  output logic              reg_WEVF,
  input  logic [7:0]        reg_readdata1,
  input  logic [7:0]        reg_readdata2,
  output logic [15:0]       alu_in1,
  output logic [15:0]       alu_in2,
  output logic [3:0]        alu_cmd,
  input  logic [15:0]       alu_out,
  input  logic              alu_carry,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              illegal
);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic              r_illegal;

  logic              w_is_legal;
  op_class_t         w_op_class;
  alu_cmd_t          w_alu_cmd;
  logic              w_writes_vx;
  logic              w_writes_vf;
  logic [ADDR_W-1:0] w_pc_step;
  logic [ADDR_W-1:0] w_pc_skip;
  logic [ADDR_W-1:0] w_pc_exec;
  logic              w_vx_is_vf;
  logic              w_unused_alu_hi;

  // Only the low byte of the ALU result is architecturally visible
  assign w_unused_alu_hi = ^alu_out[15:8];

  chip8_decode u_decode (
    .ir        (r_ir),
    .is_legal  (w_is_legal),
    .op_class  (w_op_class),
    .alu_cmd   (w_alu_cmd),
    .writes_vx (w_writes_vx),
    .writes_vf (w_writes_vf)
  );

  // State register
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; run is only sampled at instruction boundaries
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (run) w_state_nxt = S_FETCH_HI;
      S_FETCH_HI: if (mem_valid) w_state_nxt = S_FETCH_LO;
      S_FETCH_LO: if (mem_valid) w_state_nxt = S_DECODE;
      S_DECODE:   w_state_nxt = w_is_legal ? S_READ : S_ILLEGAL;
      S_READ:     w_state_nxt = S_EXEC;
      S_EXEC:     w_state_nxt = run ? S_FETCH_HI : S_IDLE;
      S_ILLEGAL:  w_state_nxt = S_ILLEGAL;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Instruction register, sticky illegal flag and PC update
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_pc      <= PC_RESET;
      r_ir      <= 16'h0000;
      r_illegal <= 1'b0;
    end else begin
      if (r_state == S_FETCH_HI && mem_valid) r_ir[15:8] <= mem_rdata;
      if (r_state == S_FETCH_LO && mem_valid) r_ir[7:0]  <= mem_rdata;
      if (r_state == S_DECODE && !w_is_legal) r_illegal <= 1'b1;
      if (r_state == S_EXEC)                  r_pc      <= w_pc_exec;
    end
  end

  // PC for the instruction completing in EXEC (wraps modulo 2^ADDR_W)
  always_comb begin
    w_pc_step = r_pc + ADDR_W'(2);
    w_pc_skip = r_pc + ADDR_W'(4);
    w_pc_exec = w_pc_step;
    case (w_op_class)
      OP_JUMP:       w_pc_exec = ADDR_W'(r_ir[11:0]);
      OP_SKIP_EQ_KK: w_pc_exec = (reg_readdata1 == r_ir[7:0])    ? w_pc_skip : w_pc_step;
      OP_SKIP_NE_KK: w_pc_exec = (reg_readdata1 != r_ir[7:0])    ? w_pc_skip : w_pc_step;
      OP_SKIP_EQ_VY: w_pc_exec = (reg_readdata1 == reg_readdata2) ? w_pc_skip : w_pc_step;
      OP_SKIP_NE_VY: w_pc_exec = (reg_readdata1 != reg_readdata2) ? w_pc_skip : w_pc_step;
      default:       w_pc_exec = w_pc_step;
    endcase
  end

  // When Vx is VF and the op also produces a flag, the flag write wins
  assign w_vx_is_vf = (r_ir[11:8] == c_vf_idx);

  // Outputs decoded from the current state
  always_comb begin
    mem_req         = 1'b0;
    mem_addr        = '0;
    reg_addr1       = 4'h0;
    reg_addr2       = 4'h0;
    reg_writedata1  = 8'h00;
    reg_WE1         = 1'b0;
    reg_VFwritedata = 8'h00;
    reg_WEVF        = 1'b0;
    alu_in1         = 16'h0000;
    alu_in2         = 16'h0000;
    alu_cmd         = 4'h0;
    case (r_state)
      S_FETCH_HI: begin
        mem_req  = 1'b1;
        mem_addr = r_pc;
      end
      S_FETCH_LO: begin
        mem_req  = 1'b1;
        mem_addr = r_pc + ADDR_W'(1);
      end
      S_DECODE, S_READ: begin
        reg_addr1 = r_ir[11:8];
        reg_addr2 = r_ir[7:4];
      end
      S_EXEC: begin
        reg_addr1 = r_ir[11:8];
        reg_addr2 = r_ir[7:4];
        case (w_op_class)
          OP_LOAD_KK: begin
            reg_writedata1 = r_ir[7:0];
            reg_WE1        = w_writes_vx;
          end
          OP_ADD_KK: begin
            alu_cmd        = w_alu_cmd;
            alu_in1        = {8'h00, reg_readdata1};
            alu_in2        = {8'h00, r_ir[7:0]};
            reg_writedata1 = alu_out[7:0];
            reg_WE1        = w_writes_vx;
          end
          OP_ALU: begin
            alu_cmd         = w_alu_cmd;
            alu_in1         = {8'h00, reg_readdata1};
            alu_in2         = {8'h00, reg_readdata2};
            reg_writedata1  = (w_alu_cmd == ALU_MOV) ? reg_readdata2 : alu_out[7:0];
            reg_WE1         = w_writes_vx && !(w_writes_vf && w_vx_is_vf);
            reg_WEVF        = w_writes_vf;
            reg_VFwritedata = {7'b0, alu_carry};
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign pc      = r_pc;
  assign illegal = r_illegal;
  assign busy    = (r_state != S_IDLE) && (r_state != S_ILLEGAL);

endmodule
`default_nettype wire
